// File: rtl/spart_fifo.sv
// spart_fifo: bus-addressed full-duplex UART with TX/RX FIFOs, optional parity,
// sticky error flags and internal loopback.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   iocs     chip select; every cycle with iocs = 1 is one bus access
//   iorw     1 = read, 0 = write
//   ioaddr   00 data, 01 status/control, 10 divisor low, 11 divisor high
//   databus  bidirectional data bus, driven only while iocs && iorw
//   rda      RX FIFO holds at least one character
//   tbr      TX FIFO can accept a character
//   txd      serial output, idle high (held high in loopback)
//   rxd      serial input, asynchronous
//
// Status byte (addr 01 read): {pe, fe, oe, par_en, rx_full, tx_idle, tbr, rda}
// Control byte (addr 01 write): [0] par_en, [1] par_odd, [2] clear oe/fe/pe, [3] loopback
module spart_fifo #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd163
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } ser_state_t;

  // Bus decode
  logic wr_acc, rd_acc;
  logic wr_data, wr_ctrl, wr_divl, wr_divh;
  assign wr_acc  = iocs && !iorw;
  assign rd_acc  = iocs && iorw;
  assign wr_data = wr_acc && (ioaddr == 2'b00);
  assign wr_ctrl = wr_acc && (ioaddr == 2'b01);
  assign wr_divl = wr_acc && (ioaddr == 2'b10);
  assign wr_divh = wr_acc && (ioaddr == 2'b11);

  // Control, divisor and sticky flags
  logic [15:0] div;
  logic        par_en, par_odd, loopback;
  logic        oe, fe, pe;
  logic        oe_set, fe_set, pe_set, flag_clr;
  assign flag_clr = wr_ctrl && databus[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= DIV_RESET;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      loopback <= 1'b0;
      oe       <= 1'b0;
      fe       <= 1'b0;
      pe       <= 1'b0;
    end else begin
      if (wr_divl) div[7:0]  <= databus;
      if (wr_divh) div[15:8] <= databus;
      if (wr_ctrl) begin
        par_en   <= databus[0];
        par_odd  <= databus[1];
        loopback <= databus[3];
      end
      // A new error in the same cycle as a clear wins, so no event is lost.
      oe <= oe_set ? 1'b1 : (flag_clr ? 1'b0 : oe);
      fe <= fe_set ? 1'b1 : (flag_clr ? 1'b0 : fe);
      pe <= pe_set ? 1'b1 : (flag_clr ? 1'b0 : pe);
    end
  end

  // Baud generator: tick16 every (div + 1) clocks; a divisor write restarts the count.
  logic [15:0] bcnt;
  logic        tick16;
  assign tick16 = (bcnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              bcnt <= DIV_RESET;
    else if (wr_divl)      bcnt <= {div[15:8], databus};
    else if (wr_divh)      bcnt <= {databus, div[7:0]};
    else if (tick16)       bcnt <= div;
    else                   bcnt <= bcnt - 16'd1;
  end

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp, tx_rp;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0]) && (tx_wp[AW] != tx_rp[AW]);
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign tx_push  = wr_data && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= databus[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
    end
  end

  // TX FSM
  ser_state_t        tx_state, tx_state_nxt;
  logic [3:0]        tx_tcnt, tx_bcnt;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par, tx_bit_end, txd_int, tx_idle;
  assign tx_bit_end = tick16 && (tx_tcnt == 4'd15);
  assign tx_idle    = (tx_state == S_IDLE) && tx_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 4'd0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_pop)                                tx_tcnt <= 4'd0;
      else if (tick16 && tx_state != S_IDLE)     tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_pop)                                tx_bcnt <= 4'd0;
      else if (tx_state == S_DATA && tx_bit_end) tx_bcnt <= tx_bcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift <= tx_head;
      tx_par   <= parity_bit(tx_head, par_odd);
    end else if (tx_state == S_DATA && tx_bit_end) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    txd_int      = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        txd_int = 1'b0;
        if (tx_bit_end) tx_state_nxt = S_DATA;
      end
      S_DATA: begin
        txd_int = tx_shift[0];
        if (tx_bit_end && tx_bcnt == LAST_BIT) tx_state_nxt = par_en ? S_PAR : S_STOP;
      end
      S_PAR: begin
        txd_int = tx_par;
        if (tx_bit_end) tx_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next start bit so back-to-back frames have no gap.
        if (tx_bit_end) begin
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_state_nxt = S_START;
          end else begin
            tx_state_nxt = S_IDLE;
          end
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  assign txd = loopback ? 1'b1 : txd_int;

  // RX input synchroniser and edge detect
  logic rxd_p0, rxd_p1, rx_line, rx_prev, rx_fall;
  assign rx_line = loopback ? txd_int : rxd_p1;
  assign rx_fall = rx_prev && !rx_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p0  <= 1'b1;
      rxd_p1  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rxd_p0  <= rxd;
      rxd_p1  <= rxd_p0;
      rx_prev <= rx_line;
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       rx_wp, rx_rp;
  logic              rx_empty, rx_full, rx_push, rx_pop, rx_done;
  logic [DATA_W-1:0] rx_head, rx_shift;
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0]) && (rx_wp[AW] != rx_rp[AW]);
  assign rx_pop   = rd_acc && (ioaddr == 2'b00) && !rx_empty;
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  assign oe_set   = rx_done && rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
    end
  end

  // RX FSM: START is checked mid-bit (8 ticks), later bits every 16 ticks from there.
  ser_state_t rx_state, rx_state_nxt;
  logic [3:0] rx_tcnt, rx_bcnt;
  logic       rx_start_smp, rx_bit_smp;
  assign rx_start_smp = (rx_state == S_START) && tick16 && (rx_tcnt == 4'd7);
  assign rx_bit_smp   = tick16 && (rx_tcnt == 4'd15);
  assign pe_set = (rx_state == S_PAR) && rx_bit_smp &&
                  (rx_line != parity_bit(rx_shift, par_odd));
  assign fe_set = (rx_state == S_STOP) && rx_bit_smp && !rx_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_tcnt  <= 4'd0;
      rx_bcnt  <= 4'd0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == S_IDLE || rx_start_smp) rx_tcnt <= 4'd0;
      else if (tick16)                        rx_tcnt <= rx_tcnt + 4'd1;
      if (rx_state != S_DATA)                 rx_bcnt <= 4'd0;
      else if (rx_bit_smp)                    rx_bcnt <= rx_bcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_bit_smp) rx_shift <= {rx_line, rx_shift[DATA_W-1:1]};
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_done      = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_state_nxt = S_START;
      S_START: if (rx_start_smp) rx_state_nxt = rx_line ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_smp && rx_bcnt == LAST_BIT) rx_state_nxt = par_en ? S_PAR : S_STOP;
      S_PAR:   if (rx_bit_smp) rx_state_nxt = S_STOP;
      S_STOP: begin
        // Framing errors still deliver the character; fe records the problem.
        if (rx_bit_smp) begin
          rx_done      = 1'b1;
          rx_state_nxt = S_IDLE;
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // Read mux (combinational) and bus driver
  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00:   if (!rx_empty) rdata[DATA_W-1:0] = rx_head;
      2'b01:   rdata = {pe, fe, oe, par_en, rx_full, tx_idle, !tx_full, !rx_empty};
      2'b10:   rdata = div[7:0];
      default: rdata = div[15:8];
    endcase
  end

  assign databus = rd_acc ? rdata : 8'bzzzzzzzz;
  assign rda     = !rx_empty;
  assign tbr     = !tx_full;

endmodule

// File: tb/tb_spart_fifo.sv
module tb_spart_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       rda, tbr, txd;
  wire  [7:0] databus;
  logic [7:0] dbus_drv = 8'h00;
  logic       drv_en = 1'b0;
  logic       probe = 1'b0;

  assign databus = drv_en ? dbus_drv : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  spart_fifo dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  // kind 0: bus read value, kind 1: {txd, rda, tbr}, kind 2: idle bus value
  typedef struct {
    int         kind;
    string      name;
    logic [7:0] expv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bit_clk = 64;

  // Monitor: compares whenever the DUT presents a read or a pin probe is requested.
  exp_t       m_e;
  logic [7:0] m_act;
  always @(negedge clk) begin
    if ((iocs && iorw) || probe) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%h want none", databus);
      end else begin
        m_e = sb.pop_front();
        case (m_e.kind)
          0:       m_act = databus;
          1:       m_act = {5'b00000, txd, rda, tbr};
          default: m_act = databus;
        endcase
        n_cmp++;
        if (m_act !== m_e.expv) begin
          n_bad++;
          $display("FAIL %s: got 0x%h want 0x%h", m_e.name, m_act, m_e.expv);
        end
      end
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; dbus_drv = d; drv_en = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    @(posedge clk); #1;
    sb.push_back('{kind: 0, name: nm, expv: e});
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic probe_pins(input logic [2:0] e, input string nm);
    sb.push_back('{kind: 1, name: nm, expv: {5'b00000, e}});
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic probe_bus_idle(input string nm);
    sb.push_back('{kind: 2, name: nm, expv: 8'bzzzzzzzz});
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic wait_rda(input int limit, input string nm);
    int n = 0;
    while (!rda && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (!rda) begin
      n_bad++;
      $display("FAIL %s: got rda=0 after %0d clk want rda=1", nm, n);
    end
  endtask

  task automatic wait_txd_low(input int limit, input string nm);
    int n = 0;
    while (txd && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (txd) begin
      n_bad++;
      $display("FAIL %s: got txd=1 after %0d clk want txd=0", nm, n);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk); #1;
    rxd = b;
    repeat (bit_clk - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                            input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(pbit);
    drive_bit(sbit);
    @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  logic [7:0] rx_vec [9] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h5A, 8'h7E, 8'h42, 8'h99};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    probe_pins(3'b101, "reset_pins");
    probe_bus_idle("reset_bus_z");
    @(negedge clk) rst = 1'b1;
    bus_rd(2'b01, 8'h06, "reset_status");
    bus_rd(2'b10, 8'hA3, "reset_div_lo");
    bus_rd(2'b11, 8'h00, "reset_div_hi");
    bus_rd(2'b00, 8'h00, "reset_data_empty");

    // Loopback single character, divisor 3 (tick = 4 clk)
    bus_wr(2'b01, 8'h08);
    bus_wr(2'b10, 8'h03);
    bus_wr(2'b11, 8'h00);
    bus_rd(2'b10, 8'h03, "div_lo_readback");
    bus_wr(2'b00, 8'hA5);
    wait_rda(3000, "lb_rda_wait");
    bus_rd(2'b00, 8'hA5, "lb_data");
    bus_rd(2'b00, 8'h00, "lb_data_empty");
    probe_pins(3'b101, "lb_after_pop_pins");
    repeat (200) @(posedge clk);

    // TX FIFO fill: byte 1 leaves for the shifter, 2..9 fill the FIFO, 10 is dropped
    for (int i = 1; i <= 10; i++) bus_wr(2'b00, 8'(i));
    bus_rd(2'b01, 8'h00, "tx_full_status");
    probe_pins(3'b100, "tx_full_pins");
    for (int i = 1; i <= 9; i++) begin
      wait_rda(3000, "lb_burst_wait");
      bus_rd(2'b00, 8'(i), "lb_burst_data");
    end
    repeat (1000) @(posedge clk);
    bus_rd(2'b01, 8'h06, "tx_drop_status");

    // RX overrun from the pin: 9 frames, none read
    bus_wr(2'b01, 8'h00);
    for (int i = 0; i < 9; i++) send_frame(rx_vec[i], 1'b0, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    bus_rd(2'b01, 8'h2F, "overrun_status");
    for (int i = 0; i < 8; i++) bus_rd(2'b00, rx_vec[i], "overrun_data");
    bus_rd(2'b01, 8'h26, "oe_sticky_status");
    bus_wr(2'b01, 8'h04);
    bus_rd(2'b01, 8'h06, "oe_cleared_status");

    // Parity and framing errors (even parity), then a clean odd-parity frame
    bus_wr(2'b01, 8'h01);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    bus_rd(2'b01, 8'h97, "pe_status");
    bus_rd(2'b00, 8'h07, "pe_data");
    bus_wr(2'b01, 8'h05);
    bus_rd(2'b01, 8'h16, "pe_cleared_status");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (100) @(posedge clk);
    bus_rd(2'b01, 8'h57, "fe_status");
    bus_rd(2'b00, 8'h07, "fe_data");
    bus_wr(2'b01, 8'h07);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    bus_rd(2'b01, 8'h17, "odd_ok_status");
    bus_rd(2'b00, 8'h03, "odd_ok_data");

    // Glitch rejection: divisor 7 gives 8-clk ticks, so 40 clk is well under 8 ticks
    bus_wr(2'b01, 8'h04);
    bus_wr(2'b10, 8'h07);
    bus_rd(2'b10, 8'h07, "div7_readback");
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    probe_pins(3'b101, "glitch_pins");
    bus_rd(2'b01, 8'h06, "glitch_status");

    // Reset in the middle of a transmitted frame
    bus_wr(2'b00, 8'h00);
    wait_txd_low(200, "tx_start_wait");
    repeat (300) @(posedge clk);
    #1;
    probe_pins(3'b001, "midframe_pins");
    @(posedge clk); #2;
    rst = 1'b0;
    probe_pins(3'b101, "async_reset_pins");
    bus_rd(2'b01, 8'h06, "in_reset_status");
    bus_rd(2'b10, 8'hA3, "in_reset_div_lo");
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    probe_pins(3'b101, "post_reset_pins");
    bus_rd(2'b01, 8'h06, "post_reset_status");

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
